// File: rtl/au_operand_seq_pkg.sv
// Shared state, mode and width definitions for the AU operand sequencer.
package au_operand_seq_pkg;

    localparam int AU_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_EMIT0  = 2'd2,
        ST_EMIT1  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_AB = 2'd0,
        MODE_BA = 2'd1,
        MODE_A  = 2'd2,
        MODE_B  = 2'd3
    } mode_t;

    // Modes that lead with operand B drive the mux select high on the first beat.
    function automatic logic first_sel(input mode_t mode);
        return (mode == MODE_BA) || (mode == MODE_B);
    endfunction

    function automatic logic is_two_beat(input mode_t mode);
        return (mode == MODE_AB) || (mode == MODE_BA);
    endfunction

endpackage

// File: rtl/au_operand_seq.sv
// Operand sequencer: collects A and B over a shared handshake bus, then drives
// the 2:1 operand mux select to emit one or two result beats per operation.
module au_operand_seq
    import au_operand_seq_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             sel,
    output logic             res_valid,
    output logic             res_last,
    input  logic             res_ready,
    output logic [7:0]       op_count
);

    state_t           state;
    state_t           state_next;
    mode_t            mode;
    mode_t            mode_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic             sel_next;
    logic [7:0]       count_next;

    // Handshake outputs come from state alone so no input reaches them combinationally.
    assign in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign res_valid = (state == ST_EMIT0) || (state == ST_EMIT1);
    assign res_last  = (state == ST_EMIT1) || ((state == ST_EMIT0) && !is_two_beat(mode));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= MODE_AB;
            a_out    <= '0;
            b_out    <= '0;
            sel      <= 1'b0;
            op_count <= 8'd0;
        end else begin
            mode     <= mode_next;
            a_out    <= a_next;
            b_out    <= b_next;
            sel      <= sel_next;
            op_count <= count_next;
        end
    end

    // Abort wins over everything and also swallows any beat offered alongside it.
    always_comb begin
        state_next = state;
        mode_next  = mode;
        a_next     = a_out;
        b_next     = b_out;
        sel_next   = sel;
        count_next = op_count;
        if (abort) begin
            state_next = ST_LOAD_A;
            a_next     = '0;
            b_next     = '0;
            sel_next   = 1'b0;
        end else begin
            case (state)
                ST_LOAD_A: begin
                    if (in_valid) begin
                        a_next     = in_data;
                        mode_next  = mode_t'(in_mode);
                        state_next = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (in_valid) begin
                        b_next     = in_data;
                        sel_next   = first_sel(mode);
                        state_next = ST_EMIT0;
                    end
                end
                ST_EMIT0: begin
                    if (res_ready) begin
                        if (is_two_beat(mode)) begin
                            state_next = ST_EMIT1;
                            sel_next   = ~sel;
                        end else begin
                            state_next = ST_LOAD_A;
                            count_next = op_count + 8'd1;
                        end
                    end
                end
                ST_EMIT1: begin
                    if (res_ready) begin
                        state_next = ST_LOAD_A;
                        count_next = op_count + 8'd1;
                    end
                end
                default: state_next = ST_LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_au_operand_seq.sv
// Bench for au_operand_seq: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based beat model.
module tb_au_operand_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort;
    logic [3:0] in_data;
    logic [1:0] in_mode;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       sel;
    logic       res_valid;
    logic       res_last;
    logic       res_ready;
    logic [7:0] op_count;
    logic [3:0] mux_out;

    int checks   = 0;
    int failures = 0;

    au_operand_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .sel       (sel),
        .res_valid (res_valid),
        .res_last  (res_last),
        .res_ready (res_ready),
        .op_count  (op_count)
    );

    assign mux_out = sel ? b_out : a_out;

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Model: a queue of result beats still owed downstream, plus the operand registers.
    typedef struct packed {
        logic [3:0] val;
        logic       sel;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic       m_loaded;
    logic [1:0] m_mode;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic       m_sel;
    logic [7:0] m_count;
    logic       rst_seen = 1'b0;

    always @(posedge rst) rst_seen = 1'b1;

    task automatic model_reset();
        exp_q.delete();
        m_loaded = 1'b0;
        m_mode   = 2'd0;
        m_a      = 4'h0;
        m_b      = 4'h0;
        m_sel    = 1'b0;
        m_count  = 8'd0;
    endtask

    task automatic model_step();
        if (abort) begin
            exp_q.delete();
            m_loaded = 1'b0;
            m_a      = 4'h0;
            m_b      = 4'h0;
            m_sel    = 1'b0;
        end else if (exp_q.size() == 0) begin
            if (in_valid) begin
                if (!m_loaded) begin
                    m_a      = in_data;
                    m_mode   = in_mode;
                    m_loaded = 1'b1;
                end else begin
                    m_b      = in_data;
                    m_loaded = 1'b0;
                    case (m_mode)
                        2'd0: begin
                            exp_q.push_back('{val: m_a, sel: 1'b0, last: 1'b0});
                            exp_q.push_back('{val: m_b, sel: 1'b1, last: 1'b1});
                        end
                        2'd1: begin
                            exp_q.push_back('{val: m_b, sel: 1'b1, last: 1'b0});
                            exp_q.push_back('{val: m_a, sel: 1'b0, last: 1'b1});
                        end
                        2'd2:    exp_q.push_back('{val: m_a, sel: 1'b0, last: 1'b1});
                        default: exp_q.push_back('{val: m_b, sel: 1'b1, last: 1'b1});
                    endcase
                    m_sel = exp_q[0].sel;
                end
            end
        end else if (res_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_count = m_count + 8'd1;
            else                   m_sel   = exp_q[0].sel;
        end
    endtask

    // Outputs are compared on the falling edge, then the model advances for the next rising edge.
    always @(negedge clk) begin
        if (rst || rst_seen) begin
            model_reset();
            rst_seen = 1'b0;
        end
        if (!rst) begin
            check_output("model_in_ready", in_ready, exp_q.size() == 0);
            check_output("model_res_valid", res_valid, exp_q.size() != 0);
            check_output("model_a_out", a_out, m_a);
            check_output("model_b_out", b_out, m_b);
            check_output("model_sel", sel, m_sel);
            check_output("model_op_count", op_count, m_count);
            if (exp_q.size() != 0) begin
                check_output("model_mux_out", mux_out, exp_q[0].val);
                check_output("model_res_last", res_last, exp_q[0].last);
            end else begin
                check_output("model_res_last_idle", res_last, 1'b0);
            end
            model_step();
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_mode   = 2'd0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offers A (with mode) then B on back-to-back cycles; ends in the first result cycle.
    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic [1:0] mode);
        in_valid = 1'b1;
        in_data  = a;
        in_mode  = mode;
        cycle();
        in_data  = b;
        in_mode  = 2'(~mode);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_cleared(input string tag, input logic [7:0] count);
        check_output({tag, "_in_ready"}, in_ready, 1'b1);
        check_output({tag, "_res_valid"}, res_valid, 1'b0);
        check_output({tag, "_a_out"}, a_out, 4'h0);
        check_output({tag, "_b_out"}, b_out, 4'h0);
        check_output({tag, "_sel"}, sel, 1'b0);
        check_output({tag, "_op_count"}, op_count, count);
    endtask

    initial begin
        apply_reset();
        check_idle_cleared("reset", 8'd0);
        check_output("reset_res_last", res_last, 1'b0);

        // Mode 0: A then B.
        res_ready = 1'b1;
        apply_stimulus(4'h3, 4'hC, 2'd0);
        check_output("m0_beat1_mux", mux_out, 4'h3);
        check_output("m0_beat1_sel", sel, 1'b0);
        check_output("m0_beat1_last", res_last, 1'b0);
        cycle();
        check_output("m0_beat2_mux", mux_out, 4'hC);
        check_output("m0_beat2_sel", sel, 1'b1);
        check_output("m0_beat2_last", res_last, 1'b1);
        cycle();
        check_output("m0_op_count", op_count, 8'd1);
        check_output("m0_in_ready", in_ready, 1'b1);

        // Mode 1 with downstream stalled.
        res_ready = 1'b0;
        apply_stimulus(4'h5, 4'hA, 2'd1);
        for (int i = 0; i < 4; i++) begin
            check_output("m1_stall_valid", res_valid, 1'b1);
            check_output("m1_stall_sel", sel, 1'b1);
            check_output("m1_stall_mux", mux_out, 4'hA);
            if (i < 3) cycle();
        end
        res_ready = 1'b1;
        cycle();
        check_output("m1_beat2_mux", mux_out, 4'h5);
        check_output("m1_beat2_last", res_last, 1'b1);
        cycle();
        check_output("m1_op_count", op_count, 8'd2);

        // Single-beat modes.
        apply_stimulus(4'h3, 4'hC, 2'd2);
        check_output("m2_mux", mux_out, 4'h3);
        check_output("m2_last", res_last, 1'b1);
        cycle();
        check_output("m2_op_count", op_count, 8'd3);
        check_output("m2_in_ready", in_ready, 1'b1);
        apply_stimulus(4'h3, 4'hC, 2'd3);
        check_output("m3_mux", mux_out, 4'hC);
        check_output("m3_last", res_last, 1'b1);
        cycle();
        check_output("m3_op_count", op_count, 8'd4);

        // Abort while waiting for B; the B beat offered alongside is dropped.
        in_valid = 1'b1;
        in_data  = 4'h7;
        in_mode  = 2'd0;
        cycle();
        check_output("abort_lb_a_captured", a_out, 4'h7);
        in_data = 4'h9;
        abort   = 1'b1;
        cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle_cleared("abort_lb", 8'd4);

        // Abort during the second beat.
        apply_stimulus(4'h6, 4'h9, 2'd0);
        cycle();
        check_output("abort_e1_last", res_last, 1'b1);
        res_ready = 1'b0;
        abort     = 1'b1;
        cycle();
        abort = 1'b0;
        check_idle_cleared("abort_e1", 8'd4);

        // Randomized traffic, checked by the model on every cycle.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom);
            in_mode   = 2'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        abort    = 1'b0;
        in_valid = 1'b0;

        // Back-to-back single-beat operations until the counter wraps.
        apply_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(4'(i), 4'(i + 1), 2'd2);
            cycle();
            if (i == 254) check_output("wrap_count_255", op_count, 8'd255);
        end
        check_output("wrap_count_0", op_count, 8'd0);

        // Asynchronous reset in the middle of a first result beat.
        apply_stimulus(4'h1, 4'h2, 2'd2);
        cycle();
        res_ready = 1'b0;
        apply_stimulus(4'hE, 4'h7, 2'd0);
        check_output("pre_rst_valid", res_valid, 1'b1);
        check_output("pre_rst_count", op_count, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_cleared("async_rst", 8'd0);
        check_output("async_rst_last", res_last, 1'b0);
        rst = 1'b0;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
